// File: rtl/ifetch_responder_if.sv
// Fetch-side and physical-memory-side signals of the instruction responder.
// The slave view belongs to the responder; the master view belongs to
// whatever drives fetch requests and models physical memory.
interface ifetch_responder_if;
  logic         mem_request;
  logic [15:0]  mem_address;
  logic [15:0]  instr;
  logic         mem_resp;
  logic         invalidate;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  modport slave (
    input  mem_request, mem_address, invalidate, pmem_rdata, pmem_resp,
    output instr, mem_resp, pmem_address, pmem_read
  );

  modport master (
    output mem_request, mem_address, invalidate, pmem_rdata, pmem_resp,
    input  instr, mem_resp, pmem_address, pmem_read
  );
endinterface

// File: rtl/ifetch_responder.sv
// Single-line instruction buffer answering IF/ID fetch requests.
// Hits answer one cycle after the request is sampled; misses read the whole
// 16-byte line from physical memory, install it, then answer from the
// returned data. Every output comes straight from a register.
module ifetch_responder #(
  parameter int TAG_BITS = 12
) (
  input  logic              clk,
  input  logic              reset,
  ifetch_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

  state_t               state_q, state_d;
  logic                 valid_q, valid_d;
  logic [TAG_BITS-1:0]  tag_q, tag_d;
  logic [7:0][15:0]     line_q, line_d;
  logic [15:0]          instr_q, instr_d;
  logic                 mem_resp_q, mem_resp_d;
  logic                 pmem_read_q, pmem_read_d;
  logic [15:0]          pmem_addr_q, pmem_addr_d;
  logic [2:0]           word_sel_q, word_sel_d;
  logic                 inval_seen_q, inval_seen_d;

  logic [7:0][15:0]     rdata_words;
  logic                 hit;
  logic                 unused_addr_bit0;

  assign rdata_words      = bus.pmem_rdata;
  // Instructions are halfword aligned; the byte bit carries no information.
  assign unused_addr_bit0 = bus.mem_address[0];

  // An invalidate in the same cycle wins over a matching tag.
  assign hit = valid_q && (tag_q == bus.mem_address[15:16-TAG_BITS]) && !bus.invalidate;

  assign bus.instr        = instr_q;
  assign bus.mem_resp     = mem_resp_q;
  assign bus.pmem_read    = pmem_read_q;
  assign bus.pmem_address = pmem_addr_q;

  // State and datapath registers; reset also aborts any fill in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      valid_q      <= 1'b0;
      tag_q        <= '0;
      line_q       <= '0;
      instr_q      <= '0;
      mem_resp_q   <= 1'b0;
      pmem_read_q  <= 1'b0;
      pmem_addr_q  <= '0;
      word_sel_q   <= '0;
      inval_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      tag_q        <= tag_d;
      line_q       <= line_d;
      instr_q      <= instr_d;
      mem_resp_q   <= mem_resp_d;
      pmem_read_q  <= pmem_read_d;
      pmem_addr_q  <= pmem_addr_d;
      word_sel_q   <= word_sel_d;
      inval_seen_q <= inval_seen_d;
    end
  end

  // Next-state logic: serve hits, run line fills, and wait out the held request.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    line_d       = line_q;
    instr_d      = instr_q;
    mem_resp_d   = 1'b0;
    pmem_read_d  = pmem_read_q;
    pmem_addr_d  = pmem_addr_q;
    word_sel_d   = word_sel_q;
    inval_seen_d = inval_seen_q;

    case (state_q)
      IDLE: begin
        if (bus.invalidate) valid_d = 1'b0;
        if (bus.mem_request) begin
          if (hit) begin
            instr_d    = line_q[bus.mem_address[3:1]];
            mem_resp_d = 1'b1;
            state_d    = HOLD;
          end else begin
            // Capture the address now; later address changes do not matter.
            pmem_addr_d  = {bus.mem_address[15:4], 4'b0000};
            word_sel_d   = bus.mem_address[3:1];
            pmem_read_d  = 1'b1;
            inval_seen_d = 1'b0;
            state_d      = FILL;
          end
        end
      end

      FILL: begin
        if (bus.invalidate) inval_seen_d = 1'b1;
        if (bus.pmem_resp) begin
          line_d      = rdata_words;
          tag_d       = pmem_addr_q[15:16-TAG_BITS];
          // A line invalidated while in flight is delivered but not kept valid.
          valid_d     = !(inval_seen_q || bus.invalidate);
          pmem_read_d = 1'b0;
          if (bus.mem_request) begin
            instr_d    = rdata_words[word_sel_q];
            mem_resp_d = 1'b1;
            state_d    = HOLD;
          end else begin
            state_d = IDLE;
          end
        end
      end

      HOLD: begin
        if (bus.invalidate) valid_d = 1'b0;
        // The requester must drop the request once before the next fetch.
        if (!bus.mem_request) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ifetch_responder.sv
// Self-checking bench for ifetch_responder: a table of fetches plus
// hand-written multi-cycle sequences; responses are matched against a queue
// of expected {instr, cycle} entries.
module tb_ifetch_responder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  ifetch_responder_if bus ();

  ifetch_responder #(.TAG_BITS(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int resp_cnt = 0;
  bit prev_resp = 1'b0;

  typedef struct {
    logic [15:0] instr;
    int          cycle;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [15:0] addr;
    bit          hit;
  } vec_t;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Physical memory contents model.
  function automatic logic [15:0] mem_word(input logic [15:0] a, input int k);
    logic [15:0] base;
    logic [15:0] mul;
    base = {a[15:4], 4'h0};
    mul  = 16'(32'h9E37 * (k + 1));
    if (base == 16'h0100 && k == 2) return 16'h1234;
    return base ^ mul;
  endfunction

  function automatic logic [127:0] mem_line(input logic [15:0] a);
    logic [127:0] l;
    for (int k = 0; k < 8; k++) l[16*k +: 16] = mem_word(a, k);
    return l;
  endfunction

  // Response monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.mem_resp) begin
        resp_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got instr %h with no pending fetch (cycle %0d)", bus.instr, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("resp_instr", {16'h0, bus.instr}, {16'h0, e.instr});
          check("resp_cycle", cyc, e.cycle);
        end
        if (prev_resp) check("resp_back_to_back", 1, 0);
      end
      prev_resp = bus.mem_resp;
    end else begin
      prev_resp = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete fetch; misses are serviced after fill_delay cycles.
  task automatic fetch(input logic [15:0] addr, input bit exp_hit, input bit inv_mid);
    bus.mem_request = 1'b1;
    bus.mem_address = addr;
    if (exp_hit) begin
      sb.push_back('{instr: mem_word(addr, int'(addr[3:1])), cycle: cyc + 1});
      step();
      check("hit_no_pmem_read", {31'h0, bus.pmem_read}, 32'h0);
    end else begin
      step();
      check("miss_pmem_read", {31'h0, bus.pmem_read}, 32'h1);
      check("miss_pmem_addr", {16'h0, bus.pmem_address}, {16'h0, addr[15:4], 4'h0});
      for (int i = 0; i < 3; i++) begin
        bus.invalidate = inv_mid && (i == 0);
        step();
        check("fill_pmem_read_held", {31'h0, bus.pmem_read}, 32'h1);
      end
      bus.invalidate = 1'b0;
      bus.pmem_rdata = mem_line(addr);
      bus.pmem_resp  = 1'b1;
      sb.push_back('{instr: mem_word(addr, int'(addr[3:1])), cycle: cyc + 1});
      step();
      bus.pmem_resp = 1'b0;
      check("fill_pmem_read_drop", {31'h0, bus.pmem_read}, 32'h0);
    end
    bus.mem_request = 1'b0;
    step();
  endtask

  vec_t vecs[10];
  int   r0;

  initial begin
    bus.mem_request = 1'b0;
    bus.mem_address = '0;
    bus.invalidate  = 1'b0;
    bus.pmem_rdata  = '0;
    bus.pmem_resp   = 1'b0;

    vecs[0] = '{16'h0104, 1'b0};
    vecs[1] = '{16'h010E, 1'b1};
    vecs[2] = '{16'h0100, 1'b1};
    vecs[3] = '{16'h0202, 1'b0};
    vecs[4] = '{16'h0206, 1'b1};
    vecs[5] = '{16'h0108, 1'b0};
    vecs[6] = '{16'h0000, 1'b0};
    vecs[7] = '{16'h000E, 1'b1};
    vecs[8] = '{16'hFFFE, 1'b0};
    vecs[9] = '{16'hFFF0, 1'b1};

    // Reset state.
    step(); step();
    check("rst_instr", {16'h0, bus.instr}, 32'h0);
    check("rst_mem_resp", {31'h0, bus.mem_resp}, 32'h0);
    check("rst_pmem_read", {31'h0, bus.pmem_read}, 32'h0);
    check("rst_pmem_addr", {16'h0, bus.pmem_address}, 32'h0);
    reset = 1'b0;
    step();

    // Table of fetches.
    for (int i = 0; i < 10; i++) fetch(vecs[i].addr, vecs[i].hit, 1'b0);

    // Held request produces exactly one response.
    r0 = resp_cnt;
    bus.mem_request = 1'b1;
    bus.mem_address = 16'hFFF4;
    sb.push_back('{instr: mem_word(16'hFFF4, 2), cycle: cyc + 1});
    for (int i = 0; i < 5; i++) step();
    check("hold_instr_stable", {16'h0, bus.instr}, {16'h0, mem_word(16'hFFF4, 2)});
    bus.mem_request = 1'b0;
    step();
    check("hold_one_pulse", resp_cnt - r0, 1);

    // Address change mid-fill is ignored.
    bus.mem_request = 1'b1;
    bus.mem_address = 16'h0200;
    step();
    check("midaddr_pmem_addr", {16'h0, bus.pmem_address}, 32'h0200);
    bus.mem_address = 16'h0300;
    step(); step();
    check("midaddr_pmem_addr_kept", {16'h0, bus.pmem_address}, 32'h0200);
    bus.pmem_rdata = mem_line(16'h0200);
    bus.pmem_resp  = 1'b1;
    sb.push_back('{instr: mem_word(16'h0200, 0), cycle: cyc + 1});
    step();
    bus.pmem_resp   = 1'b0;
    bus.mem_request = 1'b0;
    step();
    fetch(16'h0300, 1'b0, 1'b0);

    // Invalidate during a fill: delivered, but the line is not kept.
    fetch(16'h0100, 1'b0, 1'b1);
    fetch(16'h0102, 1'b0, 1'b0);
    fetch(16'h0106, 1'b1, 1'b0);

    // Invalidate while idle, and together with a request.
    bus.invalidate = 1'b1;
    step();
    bus.invalidate = 1'b0;
    fetch(16'h0104, 1'b0, 1'b0);
    bus.invalidate = 1'b1;
    bus.mem_request = 1'b1;
    bus.mem_address = 16'h010C;
    step();
    bus.invalidate = 1'b0;
    check("inv_same_cycle_miss", {31'h0, bus.pmem_read}, 32'h1);
    bus.pmem_rdata = mem_line(16'h010C);
    bus.pmem_resp  = 1'b1;
    sb.push_back('{instr: mem_word(16'h010C, 6), cycle: cyc + 1});
    step();
    bus.pmem_resp   = 1'b0;
    bus.mem_request = 1'b0;
    step();

    // Reset mid-fill aborts immediately.
    bus.mem_request = 1'b1;
    bus.mem_address = 16'h0400;
    step();
    check("rstfill_pmem_read_before", {31'h0, bus.pmem_read}, 32'h1);
    reset = 1'b1;
    #1;
    check("rstfill_pmem_read", {31'h0, bus.pmem_read}, 32'h0);
    check("rstfill_mem_resp", {31'h0, bus.mem_resp}, 32'h0);
    check("rstfill_instr", {16'h0, bus.instr}, 32'h0);
    bus.mem_request = 1'b0;
    step();
    reset = 1'b0;
    step();
    fetch(16'h010C, 1'b0, 1'b0);

    // Request dropped mid-fill: line installed, no response.
    r0 = resp_cnt;
    bus.mem_request = 1'b1;
    bus.mem_address = 16'h0500;
    step();
    bus.mem_request = 1'b0;
    step();
    bus.pmem_rdata = mem_line(16'h0500);
    bus.pmem_resp  = 1'b1;
    step();
    bus.pmem_resp = 1'b0;
    step(); step();
    check("drop_no_resp", resp_cnt - r0, 0);
    fetch(16'h0506, 1'b1, 1'b0);

    // Drain and confirm nothing is outstanding.
    for (int i = 0; i < 4; i++) step();
    check("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule

// File: doc/ifetch_responder.md
Name: ifetch_responder

Overview:
Instruction-side memory responder serving the IF/ID stage's fetch handshake (mem_request / pc address -> instr / mem_resp).
- Holds a single 128-bit line buffer (8 x 16-bit lc3b_word) with tag and valid bit.
- Hits are answered in one cycle.
- Misses run a line read on the physical-memory port, install the line, then answer.
- Sits between the fetch pipeline register and physical memory (or the L2 arbiter).

Parameters:
- TAG_BITS, 12, width of stored tag (address bits [15:4]); fixed by the 16-byte line, parameterised only for lint/elaboration.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- mem_request  in  1  level fetch request from IF/ID; held high until the requester advances
- mem_address  in  16  byte address of the instruction (lc3b_word); bit 0 ignored
- instr  out  16  fetched instruction word; stable from the mem_resp cycle until the next mem_resp
- mem_resp  out  1  single-cycle response pulse
- invalidate  in  1  clears the line valid bit (e.g. store hitting code space)
- pmem_address  out  16  line-aligned address {tag,4'b0}
- pmem_read  out  1  line read strobe, held until pmem_resp
- pmem_rdata  in  128  line data; word k = bits [16k+15:16k]
- pmem_resp  in  1  single-cycle line-read completion

Behaviour:
- Reset (async): state=IDLE, valid=0, tag=0, line=0, instr=0, mem_resp=0, pmem_read=0, pmem_address=0. Asserting reset mid-fill aborts the fill immediately: pmem_read drops with reset and no line is installed.
- All outputs are registered.
- Word select: addr[3:1]. Hit means valid && tag==addr[15:4] && !invalidate in the same cycle.
- States: IDLE, FILL, HOLD.
- IDLE, mem_request=1, hit:
  - request sampled at edge N; mem_resp=1 and instr=line word during cycle N+1 (latency 1).
  - Next state HOLD.
- IDLE, mem_request=1, miss:
  - capture address at edge N; pmem_address={addr[15:4],0}; pmem_read=1 from cycle N+1.
  - Next state FILL.
- FILL:
  - pmem_read held high; mem_address changes are ignored, captured address rules.
  - On the edge sampling pmem_resp=1: line<=pmem_rdata, tag<=captured tag, valid<=1 unless invalidate seen during the fill; pmem_read<=0.
  - If mem_request is still high: instr<=selected word from pmem_rdata, mem_resp<=1, next state HOLD.
  - If mem_request dropped during the fill: install the line, no mem_resp, next state IDLE.
- HOLD: mem_resp=0 after its one cycle; instr held. Leave to IDLE when mem_request is sampled low. No new request is accepted until the low cycle, so the IF/ID advance/re-request pattern produces exactly one response per fetch.
- mem_resp is never high for two consecutive cycles.
- invalidate:
  - in IDLE/HOLD: valid<=0 next edge.
  - same cycle as an IDLE request: treated as a miss.
  - during FILL: the response is still delivered from pmem_rdata, but valid stays 0.
- pmem_resp outside FILL is ignored.
- A request with mem_address=0 is served normally; no-op detection belongs to IF/ID.

Test Plan:
- Reset then request 0x0104, miss -> pmem_read=1 with pmem_address=0x0100 next cycle. Return pmem_rdata word2=0x1234 with pmem_resp -> mem_resp pulse 1 cycle later, instr=0x1234, valid set.
- After the previous test, drop mem_request 1 cycle, then request 0x010E -> mem_resp in the next cycle with instr=word7 and no pmem_read (hit). Hold request high 5 cycles -> only one mem_resp pulse.
- Request 0x0200 after the 0x0100 fill -> miss, pmem_address=0x0200. Change mem_address to 0x0300 mid-fill -> response uses the 0x0200 line word0.
- Assert invalidate during a fill of 0x0100 -> response delivered; re-request 0x0102 -> miss, pmem_read reasserted.
- Assert reset while pmem_read=1 -> pmem_read=0, mem_resp=0, instr=0 immediately. Subsequent request to the same line -> miss.
- Drop mem_request mid-fill, then return pmem_resp -> no mem_resp. The next request to the same line hits with 1-cycle latency.
